// File: rtl/uart_rx_ovs_fifo.sv
// 16x oversampled UART receiver with 3-sample majority vote, parity/framing/break tagging,
// and a show-ahead RX FIFO with sticky overrun.
module uart_rx_ovs_fifo #(
  parameter int FIFO_DEPTH  = 16,
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [1:0]                      word_length,
  input  logic                            parity_en,
  input  logic                            parity_even,
  input  logic                            parity_stick,
  input  logic [DIV_W-1:0]                baud_div,
  input  logic                            rx,
  input  logic                            rd_en,
  input  logic                            fifo_flush,
  output logic [10:0]                     rd_data,
  output logic                            rd_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            overrun
);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY   = 3'd3,
    STOP     = 3'd4,
    BRK_WAIT = 3'd5
  } state_t;

  function automatic logic majority_f(input logic a, input logic b, input logic c);
    majority_f = (a & b) | (a & c) | (b & c);
  endfunction

  // Stick mode compares the bit alone; normal mode checks data+parity XOR against the target.
  function automatic logic parity_err_f(input logic [7:0] data, input logic pbit,
                                        input logic even, input logic stick);
    logic expected;
    expected = ~even;
    if (stick) begin
      parity_err_f = (pbit != expected);
    end else begin
      parity_err_f = ((^data ^ pbit) != expected);
    end
  endfunction

  state_t                 state_r, state_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   rx_s, rx_prev_r, fall_s;
  logic [DIV_W-1:0]       baud_cnt_r, div_s;
  logic                   tick_s, samp_s, end_s, vote_s, last_data_s, brk_s, push_s;
  logic [3:0]             tick_idx_r;
  logic                   s7_r, s8_r;
  logic [1:0]             wl_r;
  logic                   pen_r, peven_r, pstick_r;
  logic [2:0]             bit_cnt_r;
  logic [7:0]             data_r;
  logic                   pbit_r, perr_r;
  logic [10:0]            entry_s;

  logic [10:0]            mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]       count_r, count_s;
  logic                   rd_valid_r, overrun_r;
  logic                   pop_s, full_s, wr_s, ovr_set_s;

  // rx synchroniser and edge history, idle-high after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r    <= {SYNC_STAGES{1'b1}};
      rx_prev_r <= 1'b1;
    end else begin
      sync_r    <= {sync_r[SYNC_STAGES-2:0], rx};
      rx_prev_r <= rx_s;
    end
  end

  assign rx_s   = sync_r[SYNC_STAGES-1];
  assign fall_s = (state_r == IDLE) & rx_prev_r & ~rx_s;

  // baud_div of zero behaves as one so the tick never stalls
  always_comb begin
    if (baud_div == {DIV_W{1'b0}}) begin
      div_s = {{(DIV_W-1){1'b0}}, 1'b1};
    end else begin
      div_s = baud_div;
    end
  end

  assign tick_s = (baud_cnt_r >= (div_s - {{(DIV_W-1){1'b0}}, 1'b1}));

  // 1/16-bit tick counter, realigned to each detected start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt_r <= {DIV_W{1'b0}};
    end else if (fall_s || tick_s) begin
      baud_cnt_r <= {DIV_W{1'b0}};
    end else begin
      baud_cnt_r <= baud_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

  assign samp_s      = tick_s & (tick_idx_r == 4'd9);
  assign end_s       = tick_s & (tick_idx_r == 4'd15);
  assign vote_s      = majority_f(s7_r, s8_r, rx_s);
  assign last_data_s = (bit_cnt_r == ({1'b0, wl_r} + 3'd4));
  assign brk_s       = (data_r == 8'h00) & (~pen_r | ~pbit_r) & ~vote_s;
  assign entry_s     = brk_s ? 11'h600 : {1'b0, ~vote_s, perr_r, data_r};

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state and push strobe
  always_comb begin
    state_s = state_r;
    push_s  = 1'b0;
    case (state_r)
      IDLE: begin
        state_s = fall_s ? START : IDLE;
      end
      START: begin
        if (samp_s && vote_s) begin
          state_s = IDLE;
        end else if (end_s) begin
          state_s = DATA;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (end_s && last_data_s) begin
          state_s = pen_r ? PARITY : STOP;
        end else begin
          state_s = DATA;
        end
      end
      PARITY: begin
        state_s = end_s ? STOP : PARITY;
      end
      STOP: begin
        if (samp_s) begin
          push_s  = 1'b1;
          state_s = brk_s ? BRK_WAIT : IDLE;
        end else begin
          state_s = STOP;
        end
      end
      BRK_WAIT: begin
        state_s = rx_s ? IDLE : BRK_WAIT;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Frame datapath: config latch, vote samples, data and parity capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_idx_r <= 4'd0;
      s7_r       <= 1'b1;
      s8_r       <= 1'b1;
      wl_r       <= 2'd0;
      pen_r      <= 1'b0;
      peven_r    <= 1'b0;
      pstick_r   <= 1'b0;
      bit_cnt_r  <= 3'd0;
      data_r     <= 8'h00;
      pbit_r     <= 1'b0;
      perr_r     <= 1'b0;
    end else if (fall_s) begin
      tick_idx_r <= 4'd0;
      wl_r       <= word_length;
      pen_r      <= parity_en;
      peven_r    <= parity_even;
      pstick_r   <= parity_stick;
      bit_cnt_r  <= 3'd0;
      data_r     <= 8'h00;
      pbit_r     <= 1'b0;
      perr_r     <= 1'b0;
    end else begin
      if (tick_s) begin
        tick_idx_r <= tick_idx_r + 4'd1;
      end
      if (tick_s && (tick_idx_r == 4'd7)) begin
        s7_r <= rx_s;
      end
      if (tick_s && (tick_idx_r == 4'd8)) begin
        s8_r <= rx_s;
      end
      if (samp_s && (state_r == DATA)) begin
        data_r[bit_cnt_r] <= vote_s;
      end
      if (samp_s && (state_r == PARITY)) begin
        pbit_r <= vote_s;
        perr_r <= parity_err_f(data_r, vote_s, peven_r, pstick_r);
      end
      if (end_s && (state_r == DATA)) begin
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end
    end
  end

  // FIFO control: flush wins over everything; a pop frees room for a push when full
  always_comb begin
    pop_s     = rd_en & rd_valid_r & ~fifo_flush;
    full_s    = (count_r == CNT_W'(FIFO_DEPTH));
    wr_s      = push_s & ~fifo_flush & (~full_s | pop_s);
    ovr_set_s = push_s & ~fifo_flush & full_s & ~pop_s;
    if (fifo_flush) begin
      count_s = {CNT_W{1'b0}};
    end else if (wr_s && !pop_s) begin
      count_s = count_r + CNT_W'(1);
    end else if (!wr_s && pop_s) begin
      count_s = count_r - CNT_W'(1);
    end else begin
      count_s = count_r;
    end
  end

  // FIFO pointers, occupancy and sticky overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      rd_valid_r <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      count_r    <= count_s;
      rd_valid_r <= (count_s != {CNT_W{1'b0}});
      if (fifo_flush) begin
        wr_ptr_r  <= {PTR_W{1'b0}};
        rd_ptr_r  <= {PTR_W{1'b0}};
        overrun_r <= 1'b0;
      end else begin
        if (wr_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        end
        if (ovr_set_s) begin
          overrun_r <= 1'b1;
        end
      end
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= entry_s;
    end
  end

  assign rd_data    = rd_valid_r ? mem_r[rd_ptr_r] : 11'h000;
  assign rd_valid   = rd_valid_r;
  assign fifo_count = count_r;
  assign overrun    = overrun_r;

endmodule

// File: tb/tb_uart_rx_ovs_fifo.sv
// Self-checking bench for uart_rx_ovs_fifo: frame-level reference model with a queue-based
// FIFO, compared against the DUT every cycle, plus directed literal expectations.
module tb_uart_rx_ovs_fifo;
  localparam int D     = 4;
  localparam int DIV_W = 16;
  localparam int SYNC  = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       word_length = 2'd3;
  logic             parity_en = 1'b0, parity_even = 1'b0, parity_stick = 1'b0;
  logic [DIV_W-1:0] baud_div = 16'd27;
  logic             rx = 1'b1, rd_en = 1'b0, fifo_flush = 1'b0;
  logic [10:0]      rd_data;
  logic             rd_valid, overrun;
  logic [2:0]       fifo_count;

  int          checks = 0, failures = 0, cyc = 0;
  logic [10:0] mq[$];
  bit          movr = 1'b0;
  int          pend_due[$];
  logic [10:0] pend_ent[$];
  bit          rand_rd = 1'b0;
  bit          m_push, m_pop, exp_valid, bad;
  logic [10:0] m_ent;

  uart_rx_ovs_fifo #(.FIFO_DEPTH(D), .DIV_W(DIV_W), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .word_length(word_length), .parity_en(parity_en),
    .parity_even(parity_even), .parity_stick(parity_stick), .baud_div(baud_div), .rx(rx),
    .rd_en(rd_en), .fifo_flush(fifo_flush), .rd_data(rd_data), .rd_valid(rd_valid),
    .fifo_count(fifo_count), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int eff_div();
    return (baud_div == 16'd0) ? 1 : int'(baud_div);
  endfunction

  // Expected FIFO entry of one frame, straight from the character rules
  function automatic logic [10:0] exp_entry(input logic [7:0] d, input int nb, input bit pen,
                                            input bit pe, input bit ps, input bit pbit, input bit stop);
    logic [7:0] dm;
    int ones;
    bit perr;
    dm = 8'h00;
    for (int i = 0; i < nb; i++) dm[i] = d[i];
    ones = $countones(dm) + int'(pbit);
    if (!pen) perr = 1'b0;
    else if (ps) perr = (pbit == pe);
    else perr = pe ? (ones % 2 == 1) : (ones % 2 == 0);
    if (dm == 8'h00 && (!pen || !pbit) && !stop) return 11'h600;
    return {1'b0, ~stop, perr, dm};
  endfunction

  function automatic bit good_par(input logic [7:0] d, input int nb, input bit pe, input bit ps);
    int ones;
    ones = 0;
    for (int i = 0; i < nb; i++) ones += int'(d[i]);
    if (ps) return ~pe;
    return pe ? (ones % 2 == 1) : (ones % 2 == 0);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int dv);
    rx = b;
    step(16 * dv);
  endtask

  task automatic send_frame(input logic [7:0] d, input int wl, input bit pen, input bit pe,
                            input bit ps, input bit pbit, input bit stop, input int gap);
    int dv, nb, nbits;
    dv = eff_div();
    nb = wl + 5;
    nbits = 2 + nb + (pen ? 1 : 0);
    word_length = 2'(wl); parity_en = pen; parity_even = pe; parity_stick = ps;
    // pushed at the mid-stop vote: sync delay + (stop bit index * 16 + 10) ticks
    pend_due.push_back(cyc + SYNC + 1 + (16 * (nbits - 1) + 10) * dv);
    pend_ent.push_back(exp_entry(d, nb, pen, pe, ps, pbit, stop));
    send_bit(1'b0, dv);
    for (int i = 0; i < nb; i++) send_bit(d[i], dv);
    if (pen) send_bit(pbit, dv);
    send_bit(stop, dv);
    for (int i = 0; i < gap; i++) send_bit(1'b1, dv);
  endtask

  task automatic send_8n1(input logic [7:0] d);
    send_frame(d, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
  endtask

  task automatic pop1();
    rd_en = 1'b1; step(1); rd_en = 1'b0;
  endtask

  task automatic flush1();
    fifo_flush = 1'b1; step(1); fifo_flush = 1'b0;
  endtask

  task automatic wait_until(input int e);
    while (cyc < e) step(1);
  endtask

  // Per-cycle compare against the model, then advance the model to the next edge
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mq.delete();
        movr = 1'b0;
      end
      exp_valid = (mq.size() != 0);
      bad = (rd_valid !== exp_valid) || (int'(fifo_count) !== mq.size()) || (overrun !== movr) ||
            (exp_valid && rd_data !== mq[0]);
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL cycle_cmp cyc=%0d got valid=%0b count=%0d ovr=%0b data=%03h expected valid=%0b count=%0d ovr=%0b data=%03h",
                 cyc, rd_valid, fifo_count, overrun, rd_data, exp_valid, mq.size(), movr,
                 exp_valid ? mq[0] : 11'h000);
      end
      if (rst_n) begin
        m_push = (pend_due.size() != 0) && (pend_due[0] == cyc + 1);
        if (m_push) begin
          m_ent = pend_ent.pop_front();
          void'(pend_due.pop_front());
        end
        if (fifo_flush) begin
          mq.delete();
          movr = 1'b0;
        end else begin
          m_pop = rd_en && (mq.size() != 0);
          if (m_pop) void'(mq.pop_front());
          if (m_push) begin
            if (mq.size() < D) mq.push_back(m_ent);
            else movr = 1'b1;
          end
        end
      end
    end
  end

  // Random reader / occasional flusher for the randomized phase
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rd) begin
        rd_en = ($urandom_range(0, 3) == 0);
        fifo_flush = ($urandom_range(0, 149) == 0);
      end
    end
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog cyc=%0d expected=finish", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int due, dv;
    logic [7:0] d;
    int wl;
    bit pen, pe, ps, pb, st;

    step(3);
    chk("reset_rd_valid", int'(rd_valid), 0);
    chk("reset_rd_data", int'(rd_data), 0);
    chk("reset_count", int'(fifo_count), 0);
    chk("reset_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    step(2);

    // Reset in the middle of a frame abandons it
    baud_div = 16'd4;
    rx = 1'b0;
    step(3 * 16 * 4);
    rst_n = 1'b0; rx = 1'b1;
    step(2);
    rst_n = 1'b1;
    step(12 * 16 * 4);
    chk("midframe_reset_count", int'(fifo_count), 0);

    baud_div = 16'd27;
    send_8n1(8'h55);
    chk("b55_data", int'(rd_data), 'h055);
    chk("b55_count", int'(fifo_count), 1);
    pop1();

    baud_div = 16'd4;
    send_frame(8'h16, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1);
    chk("par_err_data", int'(rd_data), 'h116);
    pop1();

    send_frame(8'hA3, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    chk("framing_data", int'(rd_data), 'h2A3);
    send_8n1(8'h0F);
    pop1();
    chk("after_framing_data", int'(rd_data), 'h00F);
    pop1();

    // Break: rx low for three 8N1 frame times
    word_length = 2'd3; parity_en = 1'b0;
    pend_due.push_back(cyc + SYNC + 1 + (16 * 9 + 10) * 4);
    pend_ent.push_back(11'h600);
    rx = 1'b0;
    step(30 * 16 * 4);
    chk("break_data", int'(rd_data), 'h600);
    chk("break_count", int'(fifo_count), 1);
    rx = 1'b1;
    step(2 * 16 * 4);
    pop1();
    send_8n1(8'h41);
    chk("post_break_data", int'(rd_data), 'h041);
    chk("post_break_count", int'(fifo_count), 1);
    pop1();

    // Glitch shorter than the sample window
    rx = 1'b0;
    step(5 * 4);
    rx = 1'b1;
    step(32 * 4);
    chk("glitch_count", int'(fifo_count), 0);
    send_8n1(8'h7E);
    chk("post_glitch_data", int'(rd_data), 'h07E);
    pop1();

    baud_div = 16'd0;
    send_8n1(8'h3C);
    chk("div0_data", int'(rd_data), 'h03C);
    pop1();

    // Overrun with a 4-deep FIFO
    baud_div = 16'd4;
    for (int i = 0; i < 5; i++) send_8n1(8'(8'h10 + i));
    chk("ovr_count", int'(fifo_count), 4);
    chk("ovr_flag", int'(overrun), 1);
    chk("ovr_head", int'(rd_data), 'h010);
    due = cyc + SYNC + 1 + (16 * 9 + 10) * 4;
    fork
      send_8n1(8'h16);
      begin
        wait_until(due - 1);
        rd_en = 1'b1; step(1); rd_en = 1'b0;
      end
    join
    chk("full_pushpop_count", int'(fifo_count), 4);
    chk("full_pushpop_ovr", int'(overrun), 1);
    chk("full_pushpop_head", int'(rd_data), 'h011);
    flush1();
    chk("flush_count", int'(fifo_count), 0);
    chk("flush_ovr", int'(overrun), 0);

    // Push coinciding with flush is discarded
    due = cyc + SYNC + 1 + (16 * 9 + 10) * 4;
    fork
      send_8n1(8'h99);
      begin
        wait_until(due - 1);
        fifo_flush = 1'b1; step(1); fifo_flush = 1'b0;
      end
    join
    chk("flush_push_count", int'(fifo_count), 0);
    chk("flush_push_ovr", int'(overrun), 0);

    // Randomized frames checked by the per-cycle model
    rand_rd = 1'b1;
    for (int f = 0; f < 30; f++) begin
      baud_div = 16'($urandom_range(0, 4));
      dv = eff_div();
      wl = $urandom_range(0, 3);
      pen = $urandom_range(0, 1);
      pe = $urandom_range(0, 1);
      ps = ($urandom_range(0, 3) == 0);
      d = 8'($urandom);
      if ($urandom_range(0, 5) == 0) d = 8'h00;
      pb = good_par(d, wl + 5, pe, ps);
      if ($urandom_range(0, 3) == 0) pb = ~pb;
      if (d == 8'h00 && $urandom_range(0, 1) == 1) pb = 1'b0;
      st = ($urandom_range(0, 5) != 0);
      send_frame(d, wl, pen, pe, ps, pb, st, $urandom_range(1, 2));
    end
    rand_rd = 1'b0;
    step(1);
    rd_en = 1'b0; fifo_flush = 1'b0;
    step(50);
    chk("pending_drained", pend_due.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
